// File: rtl/spart_pkg.sv
// spart_pkg: FSM state types and width helpers shared by the SPART serial port
package spart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Widest legal payload; sizing the bit index for it covers every legal DATA_BITS
    localparam int DATA_BITS_MAX = 9;
    localparam int BIT_IDX_W     = $clog2(DATA_BITS_MAX + 1);

    // Tick counter width for a given oversample ratio
    function automatic int tick_cnt_w(input int oversample);
        return $clog2(oversample);
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: oversample tick generator, one pulse every div_i+1 clocks
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);
    assign cnt_d  = tick_o ? div_i : cnt_q - DIV_W'(1);

    // Down-counter; a new divisor is picked up only at reload
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= div_i;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spart_os.sv
// spart_os: full-duplex UART, programmable baud tick, oversampled mid-bit receiver
// Build option: define SPART_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module spart_os
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
`ifdef SPART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 send_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tbr,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int BIT_W  = BIT_IDX_W;
    localparam int TICK_W = tick_cnt_w(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef SPART_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
    localparam bit PAR_ODD = PARITY_ODD;
`else
    localparam bit PAR_EN  = 1'b0;
    localparam bit PAR_ODD = 1'b0;
`endif

    logic tick;

    spart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .div_i  (baud_div),
        .tick_o (tick)
    );

    // ---------------------------------------------------------------- TX
    tx_state_t            tx_state_q, tx_state_d;
    logic                 tx_wait_q, tx_wait_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [TICK_W-1:0]    tx_tick_q, tx_tick_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;

    assign tbr = (tx_state_q == TX_IDLE);
    assign txd = txd_q;

    // TX state register; txd is registered so the pin never sees decode glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_wait_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_wait_q  <= tx_wait_d;
            tx_shift_q <= tx_shift_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // TX next state: the start bit waits for the first tick, then each bit lasts OVERSAMPLE ticks
    always_comb begin
        tx_state_d = tx_state_q;
        tx_wait_d  = tx_wait_q;
        tx_shift_d = tx_shift_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_par_d   = tx_par_q;
        if (tx_state_q == TX_IDLE) begin
            if (send_tx) begin
                tx_state_d = TX_START;
                tx_wait_d  = 1'b1;
                tx_shift_d = tx_data;
                tx_par_d   = (^tx_data) ^ PAR_ODD;
                tx_tick_d  = '0;
                tx_bit_d   = '0;
            end
        end else if (tick) begin
            if (tx_wait_q) begin
                tx_wait_d = 1'b0;
            end else if (tx_tick_q != TICK_LAST) begin
                tx_tick_d = tx_tick_q + TICK_W'(1);
            end else begin
                tx_tick_d = '0;
                case (tx_state_q)
                    TX_START: begin
                        tx_state_d = TX_DATA;
                        tx_bit_d   = '0;
                    end
                    TX_DATA: begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = (tx_bit_q == DATA_LAST) ? '0 : tx_bit_q + BIT_W'(1);
                        tx_state_d = (tx_bit_q != DATA_LAST) ? TX_DATA : PAR_EN ? TX_PARITY : TX_STOP;
                    end
                    TX_PARITY: begin
                        tx_state_d = TX_STOP;
                        tx_bit_d   = '0;
                    end
                    TX_STOP: begin
                        tx_bit_d   = tx_bit_q + BIT_W'(1);
                        tx_state_d = (tx_bit_q == STOP_LAST) ? TX_IDLE : TX_STOP;
                    end
                    default: tx_state_d = TX_IDLE;
                endcase
            end
        end
        txd_d = (tx_state_d == TX_DATA)   ? tx_shift_d[0] :
                (tx_state_d == TX_PARITY) ? tx_par_d :
                !((tx_state_d == TX_START) && !tx_wait_d);
    end

    // ---------------------------------------------------------------- RX
    rx_state_t            rx_state_q, rx_state_d;
    logic                 rx_s1_q, rx_s2_q;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [TICK_W-1:0]    rx_tick_q, rx_tick_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic                 rx_perr_q, rx_perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q, rda_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_out_q, perr_out_d;

    assign rx_data    = rx_data_q;
    assign rda        = rda_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_out_q;

    // Two-flop synchroniser on the asynchronous serial input; idles high
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rxd;
            rx_s2_q <= rx_s1_q;
        end
    end

    // RX state register and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_perr_q  <= 1'b0;
            rx_data_q  <= '0;
            rda_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_out_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_perr_q  <= rx_perr_d;
            rx_data_q  <= rx_data_d;
            rda_q      <= rda_d;
            ferr_q     <= ferr_d;
            perr_out_q <= perr_out_d;
        end
    end

    // RX next state: half a bit after the start edge re-checks the line, then samples every bit centre
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_perr_d  = rx_perr_q;
        rx_data_d  = rx_data_q;
        rda_d      = 1'b0;
        ferr_d     = 1'b0;
        perr_out_d = 1'b0;
        if (rx_state_q == RX_IDLE) begin
            if (!rx_s2_q) begin
                rx_state_d = RX_START;
                rx_tick_d  = '0;
                rx_bit_d   = '0;
                rx_perr_d  = 1'b0;
            end
        end else if (tick) begin
            rx_tick_d = rx_tick_q + TICK_W'(1);
            if (rx_state_q == RX_START) begin
                if (rx_tick_q == TICK_MID) begin
                    rx_tick_d  = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end else if (rx_tick_q == TICK_LAST) begin
                rx_tick_d = '0;
                case (rx_state_q)
                    RX_DATA: begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_bit_d   = (rx_bit_q == DATA_LAST) ? '0 : rx_bit_q + BIT_W'(1);
                        rx_state_d = (rx_bit_q != DATA_LAST) ? RX_DATA : PAR_EN ? RX_PARITY : RX_STOP;
                    end
                    RX_PARITY: begin
                        rx_perr_d  = rx_s2_q ^ (^rx_shift_q) ^ PAR_ODD;
                        rx_state_d = RX_STOP;
                    end
                    RX_STOP: begin
                        rx_state_d = RX_IDLE;
                        rx_data_d  = rx_shift_q;
                        rda_d      = 1'b1;
                        ferr_d     = !rx_s2_q;
                        perr_out_d = PAR_EN & rx_perr_q;
                    end
                    default: rx_state_d = RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spart_os.sv
// tb_spart_os: loopback and line-injection bench for spart_os with a receive scoreboard
module tb_spart_os;

`ifdef SPART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB  = 10 + PAR;
    localparam int BIT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic        send_tx = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tbr, txd, rda, frame_err, parity_err;
    logic [7:0]  rx_data;
    logic        inj_en = 1'b0;
    logic        inj_val = 1'b1;
    logic        rxd;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rda   = 0;
    int n_push  = 0;
    int cyc     = 0;
    logic [9:0] exp_q[$];

    assign rxd = inj_en ? inj_val : txd;

    spart_os dut (
        .clk        (clk),
        .rst        (rst),
        .baud_div   (baud_div),
        .send_tx    (send_tx),
        .tx_data    (tx_data),
        .tbr        (tbr),
        .txd        (txd),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rda        (rda),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rda pulse is matched against the oldest expected frame
    always @(negedge clk) begin
        if (!rst && rda) begin
            n_rda++;
            if (exp_q.size() == 0) begin
                check("rda_unexpected", 32'(rda), 32'd0);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e[7:0]));
                check("frame_err", 32'(frame_err), 32'(e[8]));
                check("parity_err", 32'(parity_err), 32'(e[9]));
            end
        end else if (!rst && (frame_err || parity_err)) begin
            check("err_without_rda", 32'({frame_err, parity_err}), 32'd0);
        end
    end

    task automatic send(input logic [7:0] d, input bit push);
        int k = 0;
        while (!tbr && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("tbr_wait", 32'(k < 3000), 32'd1);
        tx_data = d;
        send_tx = 1'b1;
        if (push) begin
            exp_q.push_back({2'b00, d});
            n_push++;
        end
        @(negedge clk);
        send_tx = 1'b0;
        check("tbr_busy", 32'(tbr), 32'd0);
    endtask

    task automatic wait_fall(output int c0);
        int k = 0;
        while (txd !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("tx_start_seen", 32'(k < 300), 32'd1);
        c0 = cyc;
    endtask

    task automatic tx_wave(input logic [7:0] d);
        logic [10:0] bits;
        int c0;
        int k = 0;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PAR == 1) bits[9] = ^d;
        send(d, 1'b1);
        wait_fall(c0);
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            if (i > 0) repeat (BIT) @(negedge clk);
            check($sformatf("tx_bit%0d", i), 32'(txd), 32'(bits[i]));
        end
        while (!tbr && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("tbr_frame_len", 32'(cyc - c0), 32'(BIT * NB));
    endtask

    task automatic inject(input logic [7:0] d, input bit stop_low, input bit par_flip);
        exp_q.push_back({par_flip, stop_low, d});
        n_push++;
        inj_val = 1'b1;
        inj_en  = 1'b1;
        inj_val = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            inj_val = d[i];
            repeat (BIT) @(negedge clk);
        end
        if (PAR == 1) begin
            inj_val = (^d) ^ par_flip;
            repeat (BIT) @(negedge clk);
        end
        if (stop_low) begin
            inj_val = 1'b0;
            repeat (44) @(negedge clk);
            inj_val = 1'b1;
            repeat (BIT - 44) @(negedge clk);
        end else begin
            inj_val = 1'b1;
            repeat (BIT) @(negedge clk);
        end
        repeat (128) @(negedge clk);
        inj_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k;
        int rda_before;
        repeat (4) @(negedge clk);
        check("rst_tbr", 32'(tbr), 32'd1);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rda", 32'(rda), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        tx_wave(8'hA5);
        repeat (100) @(negedge clk);

`ifdef SPART_PARITY_EN
        tx_wave(8'h07);
        repeat (100) @(negedge clk);
        inject(8'h07, 1'b0, 1'b1);
`endif

        send(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        tx_data = 8'hFF;
        send_tx = 1'b1;
        @(negedge clk);
        send_tx = 1'b0;
        check("busy_tbr", 32'(tbr), 32'd0);
        k = 0;
        while (!tbr && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("busy_hold", 32'(k >= 560 && k < 2000), 32'd1);
        repeat (100) @(negedge clk);
        check("busy_no_resend", 32'(txd), 32'd1);

        rda_before = n_rda;
        inj_val = 1'b1;
        inj_en  = 1'b1;
        inj_val = 1'b0;
        repeat (20) @(negedge clk);
        inj_val = 1'b1;
        repeat (100) @(negedge clk);
        inj_en = 1'b0;
        check("glitch_no_rda", 32'(n_rda), 32'(rda_before));
        inject(8'h81, 1'b0, 1'b0);

        inject(8'h55, 1'b1, 1'b0);

        send(8'hC3, 1'b0);
        wait_fall(c0);
        repeat (BIT / 2 + BIT * 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_tbr", 32'(tbr), 32'd1);
        check("midrst_rda", 32'(rda), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        send(8'h0F, 1'b1);

        send(8'h12, 1'b1);
        send(8'h34, 1'b1);

        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (100) @(negedge clk);
        check("rx_drain", 32'(exp_q.size()), 32'd0);
        check("rda_count", 32'(n_rda), 32'(n_push));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spart_os.md
Name: spart_os

Overview:
Parametrised successor to the existing SPART serial port: full-duplex UART with a runtime-programmable baud divisor and a 16x (parametrised) oversampled receiver that samples at mid-bit. It adds configurable data width, stop-bit count, false-start rejection and framing-error reporting. It sits between the processor's I/O register interface and the board RS-232 pins.

Parameters:
DATA_BITS, 8, payload bits per frame (5..9), LSB first
STOP_BITS, 1, stop bits transmitted (1 or 2); receiver checks only the first
OVERSAMPLE, 16, ticks per bit period; even value, >=4
DIV_W, 16, width of baud_div

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
baud_div  in  DIV_W  oversample tick period minus 1, in clk cycles
send_tx  in  1  request to transmit tx_data; honoured only while tbr=1
tx_data  in  DATA_BITS  byte to send
tbr  out  1  transmit buffer ready (idle)
txd  out  1  serial out, idle high
rxd  in  1  serial in, asynchronous
rx_data  out  DATA_BITS  last received payload
rda  out  1  one-cycle pulse: new rx_data valid
frame_err  out  1  one-cycle pulse with rda when stop bit sampled low
parity_err  out  1  one-cycle pulse with rda on parity mismatch (see Optional Feature)

Behaviour:
- Reset values: tbr=1, txd=1, rx_data=0, rda=0, frame_err=0, parity_err=0; all FSMs IDLE; rxd synchroniser flops reset to 1; tick counter loads baud_div.
- Reset asserted mid-frame: next cycle txd=1, tbr=1, RX discards the partial frame with no rda.
- Tick gen: down-counter; when 0, pulse tick for 1 cycle and reload baud_div. Period = baud_div+1 cycles; baud_div=0 gives tick every cycle. A changed baud_div takes effect at the next reload.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - send_tx&tbr in IDLE: latch tx_data; tbr=0 next cycle. send_tx while tbr=0 is ignored; no queueing.
  - START begins on the next tick; each bit holds txd for OVERSAMPLE ticks.
  - DATA shifts LSB first.
  - STOP drives 1 for STOP_BITS*OVERSAMPLE ticks.
  - tbr=1 the cycle after the final stop tick. A send_tx in that same cycle starts a back-to-back frame.
- RX synchroniser: 2 flops; FSM uses the synchronised value only.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: synchronised rxd=0 -> START; clear the tick count.
  - START: after OVERSAMPLE/2 ticks, re-sample. If 1, treat as a false start and return to IDLE with no output; otherwise go to DATA.
  - DATA/PARITY/STOP: sample once every OVERSAMPLE ticks (mid-bit). DATA shifts in LSB first.
  - STOP sample: on the next cycle, rx_data updates and rda pulses. frame_err pulses if the stop sample was 0.
  - After STOP, re-arm IDLE immediately; a start edge during remaining stop time is accepted.
  - rx_data holds until the next completed frame; errored frames still update rx_data.
- TX and RX are fully independent; simultaneous activity is legal.

Optional Feature:
Macro SPART_PARITY_EN.
- Defined: parameter PARITY_ODD (default 0) selects even/odd parity. TX inserts the parity bit after DATA. RX samples the parity bit and pulses parity_err with rda on mismatch.
- Undefined: no PARITY state in either FSM; frame = start + DATA_BITS + stop; parity_err tied 0. The port list is identical in both builds.

Decomposition:
- Package spart_pkg: tx_state_t and rx_state_t enums (IDLE, START, DATA, PARITY, STOP); localparams for bit-index width ($clog2(DATA_BITS+1)) and tick-count width ($clog2(OVERSAMPLE)).
- Sub-module spart_baud_gen (tick generator, parameter DIV_W); a single instance is shared by TX and RX.

Test Plan:
- Common setup: DATA_BITS=8, OVERSAMPLE=16, baud_div=3 (64 clk/bit), txd looped to rxd.
- Loopback: send_tx with 0xA5 -> txd shows 0,1,0,1,0,0,1,0,1,1 (64 clk each); one rda pulse with rx_data=0xA5, frame_err=0; tbr=1 after 640 cycles from the first tick.
- Busy: send 0x3C, then pulse send_tx with 0xFF while tbr=0 -> only 0x3C received; tbr stays 0 until its frame ends.
- Glitch: drive rxd low for 5 ticks (20 clk), then high -> no rda; the following valid frame 0x81 is received correctly.
- Framing: inject frame 0x55 with the stop bit low -> rda and frame_err pulse together, rx_data=0x55.
- Reset mid-frame: assert rst at data bit 3 of TX and RX -> next cycle txd=1, tbr=1, no rda; the next frame 0x0F is received correctly.
- Parity (SPART_PARITY_EN, PARITY_ODD=0): send 0x07 -> parity bit 1, parity_err=0; flip the injected parity bit -> parity_err pulses with rda.
